fizzbuzz_ctrl: RTL and testbench

- Sequencer for the fizz/buzz classification datapath.
- On a start command it runs a configurable-length sequence n = 1..L. Each n is classified as number, fizz, buzz or fizzbuzz using modulo counters; no dividers.
- Each result is emitted as one token on a valid/ready stream with full backpressure.
- Sits between the host control interface (start/length/abort) and the downstream token sink.

---
 rtl/fizzbuzz_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fizzbuzz_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_ctrl.sv
// -----------------------------------------------------------------------------
// fizzbuzz_ctrl
//
// Sequencer for the fizz/buzz classification datapath. A host start command
// launches a sequence n = 1..L. Each n is classified as number, fizz, buzz or
// fizzbuzz using two free-running modulo counters, so no divider is needed.
// Each result goes out as one token on a valid/ready stream that supports full
// backpressure.
//
// Ports
//   i_clk      clock; all logic runs on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    start request, sampled only in IDLE
//   i_length   sequence length L, sampled together with i_start
//   i_abort    terminates a running sequence
//   o_busy     high in LOAD, RUN and DONE (decoded from the state)
//   o_err      one-cycle pulse: start rejected because L was 0 or too large
//   o_done     one-cycle pulse: sequence completed normally
//   o_valid    token valid
//   i_ready    sink accepts the token
//   o_kind     0 = number, 1 = fizz, 2 = buzz, 3 = fizzbuzz
//   o_number   value n of the current token
// -----------------------------------------------------------------------------
module fizzbuzz_ctrl #(
  parameter int g_max_length = 100,
  parameter int g_fizz       = 3,
  parameter int g_buzz       = 5,
  localparam int W           = $clog2(g_max_length + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_length,
  input  logic         i_abort,
  output logic         o_busy,
  output logic         o_err,
  output logic         o_done,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [1:0]   o_kind,
  output logic [W-1:0] o_number
);

  // Residue counter widths. Each counter holds n mod divisor.
  localparam int FW = $clog2(g_fizz);
  localparam int BW = $clog2(g_buzz);

  localparam logic [FW-1:0] FIZZ_LAST = FW'(g_fizz - 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(g_buzz - 1);
  // Residues of n = 1. Both divisors are at least 2, so this is simply 1.
  localparam logic [FW-1:0] FIZZ_ONE  = FW'(1 % g_fizz);
  localparam logic [BW-1:0] BUZZ_ONE  = BW'(1 % g_buzz);
  localparam logic [W-1:0]  MAX_LEN   = W'(g_max_length);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   len_q;
  logic [W-1:0]   n_q;
  logic [FW-1:0]  rf_q;
  logic [BW-1:0]  rb_q;

  logic [FW-1:0]  rf_nxt;
  logic [BW-1:0]  rb_nxt;
  logic           handshake;
  logic           len_bad;

  // Kind encoding: bit1 = divisible by the buzz divisor, bit0 = divisible by
  // the fizz divisor. Both bits set means fizzbuzz.
  function automatic logic [1:0] kind_of(input logic [FW-1:0] rf,
                                         input logic [BW-1:0] rb);
    return {rb == '0, rf == '0};
  endfunction

  // Residues for n+1. Each counter wraps to 0 instead of dividing n.
  // NOTE: every signal driven in always_comb gets a value on every path, so no
  // latch is inferred.
  always_comb begin
    rf_nxt = (rf_q == FIZZ_LAST) ? '0 : rf_q + FW'(1);
    rb_nxt = (rb_q == BUZZ_LAST) ? '0 : rb_q + BW'(1);
  end

  assign handshake = o_valid && i_ready;
  assign len_bad   = (i_length == '0) || (i_length > MAX_LEN);

  // o_busy is the only output decoded combinationally from the state.
  assign o_busy    = (state != S_IDLE);

  // n_q drives the stream directly. It changes only on a handshake, so the
  // value stays stable while the sink stalls.
  assign o_number  = n_q;

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      len_q   <= '0;
      n_q     <= '0;
      rf_q    <= '0;
      rb_q    <= '0;
      o_valid <= 1'b0;
      o_kind  <= '0;
      o_err   <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses by default.
      o_err  <= 1'b0;
      o_done <= 1'b0;

      case (state)
        S_IDLE: begin
          // i_abort has no effect here: there is nothing to terminate.
          if (i_start) begin
            if (len_bad) begin
              o_err <= 1'b1;
            end else begin
              len_q <= i_length;
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          n_q     <= W'(1);
          rf_q    <= FIZZ_ONE;
          rb_q    <= BUZZ_ONE;
          o_kind  <= kind_of(FIZZ_ONE, BUZZ_ONE);
          o_valid <= 1'b1;
          state   <= S_RUN;
        end

        S_RUN: begin
          // Abort wins over advance. A token accepted in the same cycle counts
          // as delivered, but nothing further is presented.
          if (i_abort) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end else if (handshake) begin
            if (n_q == len_q) begin
              o_valid <= 1'b0;
              o_done  <= 1'b1;
              state   <= S_DONE;
            end else begin
              n_q    <= n_q + W'(1);
              rf_q   <= rf_nxt;
              rb_q   <= rb_nxt;
              o_kind <= kind_of(rf_nxt, rb_nxt);
            end
          end
        end

        S_DONE: begin
          // o_done was raised on entry. A start request here is dropped.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fizzbuzz_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fizzbuzz_ctrl
//
// Self-checking bench for fizzbuzz_ctrl (L_max = 100, fizz = 3, buzz = 5).
// A table of start scenarios is applied in a loop. Each accepted token is
// checked against an arithmetic classification of n. Hand-written sequences
// cover reset during a stall, and a randomized phase mixes lengths, ready
// patterns and aborts.
// -----------------------------------------------------------------------------
module tb_fizzbuzz_ctrl;

  localparam int MAXL = 100;
  localparam int W    = $clog2(MAXL + 1);

  logic         i_clk    = 1'b0;
  logic         i_rst_n  = 1'b0;
  logic         i_start  = 1'b0;
  logic [W-1:0] i_length = '0;
  logic         i_abort  = 1'b0;
  logic         i_ready  = 1'b0;
  logic         o_busy;
  logic         o_err;
  logic         o_done;
  logic         o_valid;
  logic [1:0]   o_kind;
  logic [W-1:0] o_number;

  fizzbuzz_ctrl #(
    .g_max_length(MAXL),
    .g_fizz      (3),
    .g_buzz      (5)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_length(i_length),
    .i_abort (i_abort),
    .o_busy  (o_busy),
    .o_err   (o_err),
    .o_done  (o_done),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_kind  (o_kind),
    .o_number(o_number)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;

  typedef struct {
    int len;
    int rmode;      // 1 = always ready, 2 = random, 3 = 1-0-0-1 pattern
    int abort_tok;  // 0 = no abort, else abort while this token is shown
    bit poke;       // re-pulse i_start mid-RUN and during DONE
    int exp_tok;
    int exp_done;
    int exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc_g++;
  endtask

  // Reference classification straight from the arithmetic definition.
  function automatic int ref_kind(input int n);
    return ((n % 5 == 0) ? 2 : 0) + ((n % 3 == 0) ? 1 : 0);
  endfunction

  function automatic logic ready_for(input int rmode, input int c);
    case (rmode)
      2:       return 1'($urandom_range(0, 1));
      3:       return ((c % 4) == 0) || ((c % 4) == 3);
      default: return 1'b1;
    endcase
  endfunction

  // Issues one start and follows the sequence until the controller is idle
  // again. Every presented token is checked against the expected n and kind.
  task automatic run_seq(input string tag, input int len, input int rmode,
                         input int abort_tok, input bit poke,
                         output int n_tok, output int n_done, output int n_err,
                         output bit abort_rdy, output int first_v,
                         output int last_acc);
    int budget;
    int c;
    int exp_n;
    int start_abs;
    int done_abs;
    budget    = 8 * len + 40;
    c         = 0;
    exp_n     = 1;
    n_tok     = 0;
    n_done    = 0;
    n_err     = 0;
    abort_rdy = 1'b0;
    first_v   = -1;
    last_acc  = -1;
    done_abs  = -1;
    start_abs = cyc_g;

    i_start  = 1'b1;
    i_length = W'(len);
    tick();
    i_start  = 1'b0;
    if (poke) i_length = W'(2);

    forever begin
      if (o_err) n_err++;
      if (o_done) begin
        n_done++;
        done_abs = cyc_g;
      end
      if (!o_busy) break;
      if (c >= budget) begin
        check({tag, " timeout busy"}, int'(o_busy), 0);
        break;
      end
      i_ready = ready_for(rmode, c);
      i_abort = (abort_tok > 0) && o_valid && (int'(o_number) == abort_tok);
      i_start = poke && ((c == 3) || o_done);
      if (o_valid) begin
        if (first_v < 0) first_v = cyc_g;
        check({tag, " number"}, int'(o_number), exp_n);
        check({tag, " kind"}, int'(o_kind), ref_kind(exp_n));
        if (i_ready) begin
          n_tok++;
          last_acc = cyc_g;
          if (i_abort) abort_rdy = 1'b1;
          exp_n++;
        end
      end
      tick();
      c++;
    end
    i_start = 1'b0;
    i_abort = 1'b0;

    // The start edge leads to LOAD, and the first token appears one cycle after that.
    if (first_v >= 0) check({tag, " first valid lat"}, first_v - start_abs, 2);
    if (done_abs >= 0) check({tag, " done lag"}, done_abs - last_acc, 1);
    // A hung controller is recovered so later scenarios still run.
    if (o_busy) begin
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tok, n_done, n_err, first_v, last_acc;
    bit abort_rdy;
    int prev_last;
    bit prev_done;
    int len, ab, etok, edone, eerr;
    bit lvalid;
    int k;

    vecs[0] = '{15,  1, 0, 1'b0, 15,  1, 0};
    vecs[1] = '{6,   3, 0, 1'b0, 6,   1, 0};
    vecs[2] = '{0,   1, 0, 1'b0, 0,   0, 1};
    vecs[3] = '{101, 1, 0, 1'b0, 0,   0, 1};
    vecs[4] = '{100, 1, 0, 1'b0, 100, 1, 0};
    vecs[5] = '{20,  1, 7, 1'b0, 7,   0, 0};
    vecs[6] = '{3,   1, 0, 1'b0, 3,   1, 0};
    vecs[7] = '{10,  1, 0, 1'b1, 10,  1, 0};
    vecs[8] = '{10,  1, 0, 1'b0, 10,  1, 0};

    // Reset state
    i_rst_n = 1'b0;
    tick();
    tick();
    check("reset busy",   int'(o_busy),   0);
    check("reset valid",  int'(o_valid),  0);
    check("reset err",    int'(o_err),    0);
    check("reset done",   int'(o_done),   0);
    check("reset kind",   int'(o_kind),   0);
    check("reset number", int'(o_number), 0);
    i_rst_n = 1'b1;
    tick();

    // Table-driven scenarios. Each start is issued in the first idle cycle
    // after the previous sequence.
    prev_done = 1'b0;
    prev_last = 0;
    for (int i = 0; i < 9; i++) begin
      run_seq($sformatf("vec%0d", i), vecs[i].len, vecs[i].rmode,
              vecs[i].abort_tok, vecs[i].poke,
              n_tok, n_done, n_err, abort_rdy, first_v, last_acc);
      check($sformatf("vec%0d tokens", i), n_tok,  vecs[i].exp_tok);
      check($sformatf("vec%0d done", i),   n_done, vecs[i].exp_done);
      check($sformatf("vec%0d err", i),    n_err,  vecs[i].exp_err);
      if (vecs[i].abort_tok > 0)
        check($sformatf("vec%0d abort valid", i), int'(o_valid), 0);
      // Start-to-start gap: last accept at T gives the next first valid at T+4.
      if (prev_done && vecs[i].exp_err == 0 && first_v >= 0)
        check($sformatf("vec%0d gap", i), first_v - prev_last, 4);
      prev_done = (n_done == 1);
      prev_last = last_acc;
    end

    // Reset while token 5 is stalled
    i_ready  = 1'b1;
    i_start  = 1'b1;
    i_length = W'(15);
    tick();
    i_start  = 1'b0;
    k = 0;
    while (k < 40 && !(o_valid && o_number == W'(5))) begin
      tick();
      k++;
    end
    check("rst reach token5", int'(o_number), 5);
    i_ready = 1'b0;
    i_rst_n = 1'b0;
    tick();
    check("midrst busy",   int'(o_busy),   0);
    check("midrst valid",  int'(o_valid),  0);
    check("midrst kind",   int'(o_kind),   0);
    check("midrst number", int'(o_number), 0);
    check("midrst done",   int'(o_done),   0);
    check("midrst err",    int'(o_err),    0);
    i_rst_n = 1'b1;
    run_seq("after rst", 15, 1, 0, 1'b0,
            n_tok, n_done, n_err, abort_rdy, first_v, last_acc);
    check("after rst tokens", n_tok,  15);
    check("after rst done",   n_done, 1);
    check("after rst err",    n_err,  0);

    // Randomized phase
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 9) == 0)      len = $urandom_range(101, 127);
      else if ($urandom_range(0, 9) == 0) len = 0;
      else                                len = $urandom_range(1, MAXL);
      lvalid = (len >= 1) && (len <= MAXL);
      ab = (lvalid && $urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      run_seq($sformatf("rnd%0d", r), len, 2, ab, 1'b0,
              n_tok, n_done, n_err, abort_rdy, first_v, last_acc);
      if (!lvalid) begin
        etok = 0; edone = 0; eerr = 1;
      end else if (ab > 0) begin
        etok = ab - 1 + int'(abort_rdy); edone = 0; eerr = 0;
      end else begin
        etok = len; edone = 1; eerr = 0;
      end
      check($sformatf("rnd%0d tokens", r), n_tok,  etok);
      check($sformatf("rnd%0d done", r),   n_done, edone);
      check($sformatf("rnd%0d err", r),    n_err,  eerr);
      // Idle gap in which i_abort is ignored
      repeat ($urandom_range(0, 3)) begin
        i_abort = 1'($urandom_range(0, 1));
        tick();
      end
      i_abort = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
